// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register pending-write scoreboard. Stalls decode while a
//            consumed operand still has a non-forwardable result in flight,
//            and keeps a saturating count of stall cycles.
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int LW   = 2,
  parameter int SCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_wb,
  input  logic [AW-1:0]   issue_dest,
  input  logic [LW-1:0]   issue_lat,
  input  logic            src_used,
  input  logic [AW-1:0]   chk_src,
  input  logic            dest_used,
  input  logic [AW-1:0]   chk_dest,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic [SCW-1:0]  stall_count
);

  localparam logic [SCW-1:0] c_cnt_max = {SCW{1'b1}};

  // Cycles remaining until each register's in-flight result is forwardable.
  logic [LW-1:0] r_pend [NREG];
  logic [SCW-1:0] r_stall_count;

  logic w_src_busy;
  logic w_dest_busy;
  logic w_stall;
  logic w_accept;

  // Hazard check uses only registered state and the check inputs, so issue
  // acceptance never feeds back into stall.
  always_comb begin
    w_src_busy  = src_used  && (r_pend[chk_src]  != '0);
    w_dest_busy = dest_used && (r_pend[chk_dest] != '0);
    w_stall     = w_src_busy || w_dest_busy;
    w_accept    = issue_valid && !w_stall && !flush;
  end

  // Pending counters: flush clears, an accepted write reloads (younger write
  // wins over an older countdown), otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush) begin
          r_pend[r] <= '0;
        end else if (w_accept && issue_wb && (issue_dest == AW'(r))) begin
          r_pend[r] <= issue_lat;
        end else if (r_pend[r] != '0) begin
          r_pend[r] <= r_pend[r] - LW'(1);
        end
      end
    end
  end

  // Saturating stall-cycle counter; only reset clears it, not flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != c_cnt_max)) begin
      r_stall_count <= r_stall_count + SCW'(1);
    end
  end

  // Busy flags are a straight reduction of each pending counter.
  generate
    for (genvar g = 0; g < NREG; g++) begin : g_busy
      assign busy_vec[g] = |r_pend[g];
    end
  endgenerate

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Self-checking bench for reg_scoreboard: behavioural model with a
//            per-cycle compare process, directed scenarios with literal
//            expectations, and a randomized phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int LW   = 2;
  // Narrower stall counter so saturation is reachable in a short run.
  localparam int SCW  = 12;
  localparam int MAXC = (1 << SCW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_wb = 1'b0;
  logic [AW-1:0]   issue_dest = '0;
  logic [LW-1:0]   issue_lat = '0;
  logic            src_used = 1'b0;
  logic [AW-1:0]   chk_src = '0;
  logic            dest_used = 1'b0;
  logic [AW-1:0]   chk_dest = '0;
  logic            flush = 1'b0;
  logic            stall;
  logic [NREG-1:0] busy_vec;
  logic [SCW-1:0]  stall_count;

  reg_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb(issue_wb),
    .issue_dest(issue_dest), .issue_lat(issue_lat),
    .src_used(src_used), .chk_src(chk_src),
    .dest_used(dest_used), .chk_dest(chk_dest),
    .flush(flush),
    .stall(stall), .busy_vec(busy_vec), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: remaining latency per register, and number of stall cycles seen.
  int m_pend [NREG];
  int m_cnt = 0;

  function automatic bit m_stall();
    return (src_used && m_pend[chk_src] > 0) || (dest_used && m_pend[chk_dest] > 0);
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b;
    for (int r = 0; r < NREG; r++) b[r] = (m_pend[r] > 0);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    bit st;
    bit acc;
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
      m_cnt = 0;
    end else begin
      st  = m_stall();
      acc = issue_valid && !st && !flush;
      if (st) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
      for (int r = 0; r < NREG; r++) begin
        if (flush) m_pend[r] = 0;
        else if (acc && issue_wb && int'(issue_dest) == r) m_pend[r] = int'(issue_lat);
        else if (m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(m_stall()));
      check("busy_vec", 32'(busy_vec), 32'(m_busy()));
      check("stall_count", 32'(stall_count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wb = 0; issue_dest = '0; issue_lat = '0;
    src_used = 0; chk_src = '0; dest_used = 0; chk_dest = '0; flush = 0;
  endtask

  task automatic issue(input int dest, input int lat);
    idle();
    issue_valid = 1; issue_wb = 1;
    issue_dest = AW'(dest); issue_lat = LW'(lat);
  endtask

  initial begin
    idle();
    tick(); tick();
    rst = 0;
    chk_en = 1;

    // Reset then idle
    src_used = 1; chk_src = 3'd3;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy_vec), 32'h00);
    check("rst_count", 32'(stall_count), 32'd0);
    tick();

    // Load-use: exactly one bubble
    issue(2, 1);
    tick();
    idle(); issue_valid = 1; src_used = 1; chk_src = 3'd2;
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_busy", 32'(busy_vec), 32'h04);
    tick();
    check("lu_release", 32'(stall), 32'd0);
    check("lu_busy_clr", 32'(busy_vec), 32'h00);
    check("lu_count", 32'(stall_count), 32'd1);
    tick();

    // Multi-cycle via chk_dest, plus unrelated consumer
    issue(5, 3);
    tick();
    idle(); src_used = 1; chk_src = 3'd1;
    #1;
    check("mc_unrelated", 32'(stall), 32'd0);
    issue_valid = 1; src_used = 0; dest_used = 1; chk_dest = 3'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mc_stall", 32'(stall), 32'd1);
      check("mc_busy5", 32'(busy_vec[5]), 32'd1);
      tick();
    end
    check("mc_release", 32'(stall), 32'd0);
    check("mc_count", 32'(stall_count), 32'd4);
    tick();

    // WAW: younger short write overrides older long one
    issue(4, 3);
    tick();
    issue(4, 1);
    tick();
    idle();
    check("waw_busy", 32'(busy_vec), 32'h10);
    tick();
    check("waw_clr", 32'(busy_vec), 32'h00);

    // Flush beats a simultaneous issue
    issue(6, 3);
    tick();
    issue(7, 3);
    tick();
    check("fl_pre", 32'(busy_vec), 32'hC0);
    issue(1, 2); flush = 1;
    tick();
    idle();
    check("fl_busy", 32'(busy_vec), 32'h00);
    check("fl_count", 32'(stall_count), 32'd4);

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_wb    = ($urandom_range(0, 3) != 0);
      issue_dest  = AW'($urandom_range(0, NREG - 1));
      issue_lat   = LW'($urandom_range(0, 3));
      src_used    = $urandom_range(0, 1);
      chk_src     = AW'($urandom_range(0, NREG - 1));
      dest_used   = $urandom_range(0, 1);
      chk_dest    = AW'($urandom_range(0, NREG - 1));
      flush       = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    tick(); tick(); tick(); tick();

    // Saturation: 3 stalls per 4 cycles until well past all-ones
    for (int k = 0; k < (MAXC / 3) + 6; k++) begin
      issue(0, 3);
      tick();
      idle(); src_used = 1; chk_src = 3'd0;
      tick(); tick(); tick();
    end
    idle();
    check("sat_model", 32'(m_cnt), 32'(MAXC));
    check("sat_count", 32'(stall_count), 32'(MAXC));

    // Async reset mid-countdown, between edges
    issue(3, 3);
    tick();
    idle(); src_used = 1; chk_src = 3'd3;
    #2;
    rst = 1;
    #1;
    check("ar_count", 32'(stall_count), 32'd0);
    check("ar_busy", 32'(busy_vec), 32'h00);
    check("ar_stall", 32'(stall), 32'd0);
    tick();
    rst = 0;
    idle();
    tick();
    check("ar_after", 32'(busy_vec), 32'h00);
    tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard for the pipelined core, sitting in decode beside the forwarding unit. It tracks, for each of the 8 architectural registers, how many cycles remain until an in-flight result becomes forwardable, and stalls decode when a consumed operand is not yet available. The forwarding unit then resolves every hazard this block lets through. It also counts stall cycles for performance monitoring.

## Interface
- NREG, 8, number of architectural registers
- AW, 3, register address width
- LW, 2, latency / pending-counter width
- SCW, 16, stall-counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- issue_valid  in  1  decode presents an instruction this cycle
- issue_wb  in  1  issued instruction writes a register
- issue_dest  in  AW  destination register of issued instruction
- issue_lat  in  LW  cycles until result is forwardable (0 = ALU, forwardable immediately; 1 = load; 2..3 = multi-cycle)
- src_used  in  1  instruction in decode reads chk_src
- chk_src  in  AW  source register of instruction in decode
- dest_used  in  1  instruction in decode reads chk_dest as an operand
- chk_dest  in  AW  second operand register of instruction in decode
- flush  in  1  pipeline flush; discard all pending entries
- stall  out  1  hold decode/fetch this cycle
- busy_vec  out  NREG  bit r set when pend[r] != 0
- stall_count  out  SCW  saturating count of stall cycles

## Operation
- State: pend[r], LW bits, one per register; stall_count register.
- stall (combinational) = (src_used & pend[chk_src] != 0) | (dest_used & pend[chk_dest] != 0).
- Accepted issue = issue_valid & ~stall & ~flush.
- Per clock, for each register r, in priority order:
  - flush: pend[r] <= 0.
  - Accepted issue with issue_wb and issue_dest == r: pend[r] <= issue_lat. This overrides the decrement (WAW: the younger write wins, even if it has lower latency).
  - Otherwise, if pend[r] != 0: pend[r] <= pend[r] - 1. Never wraps below 0.
- If issue_wb = 0 or issue_lat = 0, no entry is created. Other counters still decrement.
- An instruction whose source equals its own destination checks the old pend value. Its own issue does not stall it.
- stall_count increments on every cycle in which stall = 1 and saturates at all-ones. flush does not clear it. Only rst clears it.
- busy_vec[r] = |pend[r]. This output is combinational from registered state.

## Timing
- Reset (async, immediate): all pend = 0, stall_count = 0. Therefore busy_vec = 0, and stall = 0 for any check inputs.
- Issue at edge t with lat L: pend = L after t. A dependent instruction in decode during the following cycles sees stall = 1 for exactly L cycles, then stall = 0 on cycle L+1 after issue.
- A load (L = 1) followed immediately by a consumer gives exactly one bubble.
- stall depends on current-cycle check inputs with zero latency. It must not depend on issue_* inputs of the same cycle, so there is no combinational loop through issue acceptance.
- flush and accepted issue in the same cycle: flush wins, and no entry is created.
- rst asserted mid-countdown clears all state immediately. Deassertion takes effect synchronously at the next edge.

## Test plan
- Reset then idle: rst pulse; check src_used = 1, chk_src = 3 -> stall = 0, busy_vec = 0x00, stall_count = 0.
- Load-use: issue load lat = 1 to r2, next cycle decode reads r2 -> stall = 1 for 1 cycle, busy_vec = 0x04 during it, then stall = 0. stall_count = 1.
- Multi-cycle: issue lat = 3 to r5, consumer reads r5 via chk_dest -> stall high 3 cycles, busy_vec bit 5 high 3 cycles. A consumer reading unrelated r1 -> stall = 0.
- WAW override: issue lat = 3 to r4, next cycle issue lat = 1 to r4 (non-dependent) -> pend[r4] = 1, cleared after one more cycle.
- Flush: pending lat = 3 on r6 and r7, flush with a simultaneous issue to r1 lat = 2 -> next cycle busy_vec = 0x00.
- Saturation and async reset: hold a stall for 2^SCW + 5 cycles -> stall_count = 0xFFFF. Assert rst between clock edges -> stall_count = 0 and busy_vec = 0 immediately.
